// File: rtl/poly_stream_tx_pkg.sv
// Shared defaults and FSM encoding for the polynomial stream transmitter.
package poly_stream_tx_pkg;

  localparam int PS_GF    = 12;
  localparam int PS_T     = 64;
  localparam int PS_CNT_W = $clog2(PS_T);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    SEND = 2'd1,
    FIN  = 2'd2
  } state_t;

endpackage

// File: rtl/poly_stream_tx.sv
// Captures a T-coefficient GF(2^m) polynomial and streams it out one coefficient per valid/ready handshake.
// Optional degree / all-zero tracking is built when POLY_STREAM_DEG_EN is defined.
module poly_stream_tx
  import poly_stream_tx_pkg::*;
#(
  parameter int GF    = PS_GF,
  parameter int T     = PS_T,
  parameter int CNT_W = $clog2(T)
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic [GF*T-1:0]   poly_in,
  output logic              busy,
  output logic [GF-1:0]     out_data,
  output logic              out_valid,
  input  logic              out_ready,
  output logic              out_last,
`ifdef POLY_STREAM_DEG_EN
  output logic [CNT_W-1:0]  deg,
  output logic              poly_zero,
  output logic              done
`else
  output logic              done
`endif
);

  // Handshake: a coefficient transfers on a rising edge where out_valid && out_ready;
  // out_valid stays high from the first coefficient until the final transfer.
  state_t           r_state;
  state_t           w_next_state;
  logic [GF*T-1:0]  r_shift;
  logic [CNT_W-1:0] r_idx;
  logic [GF-1:0]    w_coeff;
  logic             w_hs;
  logic             w_at_last;
  logic             w_capture;

  assign w_coeff   = r_shift[GF-1:0];
  assign w_at_last = (r_idx == CNT_W'(T - 1));
  assign w_hs      = (r_state == SEND) && out_ready;
  assign w_capture = (r_state == IDLE) && start;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_next_state;
    end
  end

  always_comb begin
    w_next_state = r_state;
    busy         = 1'b0;
    out_valid    = 1'b0;
    out_last     = 1'b0;
    done         = 1'b0;
    out_data     = w_coeff;
    case (r_state)
      IDLE: begin
        if (start) w_next_state = SEND;
      end
      SEND: begin
        busy      = 1'b1;
        out_valid = 1'b1;
        out_last  = w_at_last;
        if (w_hs && w_at_last) w_next_state = FIN;
      end
      FIN: begin
        done         = 1'b1;
        w_next_state = IDLE;
      end
      default: w_next_state = IDLE;
    endcase
  end

  // After T shifts the register is empty, so out_data naturally rests at zero outside a stream.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_shift <= '0;
      r_idx   <= '0;
    end else if (w_capture) begin
      r_shift <= poly_in;
      r_idx   <= '0;
    end else if (w_hs) begin
      r_shift <= r_shift >> GF;
      if (!w_at_last) r_idx <= r_idx + 1'b1;
    end
  end

`ifdef POLY_STREAM_DEG_EN
  logic [CNT_W-1:0] r_deg;
  logic             r_poly_zero;
  logic [CNT_W-1:0] r_deg_trk;
  logic             r_zero_trk;
  logic             w_nz;

  assign w_nz      = (w_coeff != '0);
  assign deg       = r_deg;
  assign poly_zero = r_poly_zero;

  // Trackers follow the stream; the visible outputs load on the final transfer so they appear with done.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_deg       <= '0;
      r_poly_zero <= 1'b0;
      r_deg_trk   <= '0;
      r_zero_trk  <= 1'b1;
    end else if (w_capture) begin
      r_deg       <= '0;
      r_poly_zero <= 1'b0;
      r_deg_trk   <= '0;
      r_zero_trk  <= 1'b1;
    end else if (w_hs) begin
      if (w_nz) begin
        r_deg_trk  <= r_idx;
        r_zero_trk <= 1'b0;
      end
      if (w_at_last) begin
        r_deg       <= w_nz ? r_idx : r_deg_trk;
        r_poly_zero <= r_zero_trk && !w_nz;
      end
    end
  end
`endif

endmodule

// File: tb/tb_poly_stream_tx.sv
// Scoreboard bench for poly_stream_tx: directed streams, backpressure, ignored starts, reset abort.
// Degree checks are compiled in when POLY_STREAM_DEG_EN is defined.
module tb_poly_stream_tx;
  localparam int GF    = 12;
  localparam int T     = 64;
  localparam int CNT_W = $clog2(T);

  logic              clk;
  logic              rst_n;
  logic              start;
  logic [GF*T-1:0]   poly_in;
  logic              busy;
  logic [GF-1:0]     out_data;
  logic              out_valid;
  logic              out_ready;
  logic              out_last;
  logic              done;
`ifdef POLY_STREAM_DEG_EN
  logic [CNT_W-1:0]  deg;
  logic              poly_zero;
`endif

  poly_stream_tx #(.GF(GF), .T(T), .CNT_W(CNT_W)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .start     (start),
    .poly_in   (poly_in),
    .busy      (busy),
    .out_data  (out_data),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_last  (out_last),
`ifdef POLY_STREAM_DEG_EN
    .deg       (deg),
    .poly_zero (poly_zero),
`endif
    .done      (done)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // scoreboard state: entries are {last, coefficient}
  logic [GF:0] exp_q[$];
  int checks    = 0;
  int failures  = 0;
  int hs_cnt    = 0;
  int done_cnt  = 0;
  int start_cyc = 0;
  int exp_deg   = 0;
  bit exp_pz    = 1'b0;
  bit          hold_pending = 1'b0;
  logic [GF:0] hold_val;
  bit          bp_en = 1'b0;

  task automatic check(input string name, input longint act, input longint req);
    checks++;
    if (act != req) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, req, cyc);
    end
  endtask

  function automatic logic [GF-1:0] coef(input int kind, input int i);
    case (kind)
      0:       return GF'(i + 1);
      1:       return GF'(i * 37 + 5);
      2:       return 12'hF00 | GF'(i);
      3:       return 12'h0AA;
      4:       return 12'h5A5 ^ GF'(i);
      5:       return (i == 37) ? 12'hABC : 12'h000;
      default: return 12'h000;
    endcase
  endfunction

  // monitor: pops on each handshake, checks hold-stability under backpressure and done cycle
  always @(negedge clk) begin
    if (!rst_n) begin
      hold_pending = 1'b0;
    end else begin
      if (out_valid) begin
        if (hold_pending) begin
          checks++;
          if ({out_last, out_data} != hold_val) begin
            failures++;
            $display("FAIL hold_stable: got %0h expected %0h (cycle %0d)", {out_last, out_data}, hold_val, cyc);
          end
        end
        if (out_ready) begin
          hold_pending = 1'b0;
          hs_cnt++;
          if (exp_q.size() == 0) begin
            check("unexpected_handshake", {out_last, out_data}, -1);
          end else begin
            logic [GF:0] e;
            e = exp_q.pop_front();
            check("out_data", out_data, e[GF-1:0]);
            check("out_last", out_last, e[GF]);
          end
        end else begin
          hold_pending = 1'b1;
          hold_val     = {out_last, out_data};
        end
      end else begin
        hold_pending = 1'b0;
      end
      if (done) begin
        done_cnt++;
        check("done_busy", busy, 0);
        check("done_valid", out_valid, 0);
        check("done_q_empty", exp_q.size(), 0);
`ifdef POLY_STREAM_DEG_EN
        check("deg", deg, exp_deg);
        check("poly_zero", poly_zero, exp_pz);
`endif
      end
    end
  end

  // ready driver: 1,0,0,1 pattern while backpressure is enabled
  initial begin
    bit [3:0] pat;
    int ph;
    pat = 4'b1001;
    ph = 0;
    out_ready = 1'b1;
    forever begin
      @(posedge clk);
      #1;
      if (bp_en) begin
        out_ready = pat[ph % 4];
        ph++;
      end else begin
        out_ready = 1'b1;
      end
    end
  end

  // driver tasks (callers sit 1 time unit after a rising edge)
  task automatic launch(input int kind, input bit push_exp);
    logic [GF*T-1:0] p;
    for (int i = 0; i < T; i++) p[i*GF +: GF] = coef(kind, i);
    if (push_exp) begin
      exp_deg = 0;
      exp_pz  = 1'b1;
      for (int i = 0; i < T; i++) begin
        exp_q.push_back({(i == T - 1), coef(kind, i)});
        if (coef(kind, i) != 0) begin
          exp_deg = i;
          exp_pz  = 1'b0;
        end
      end
    end
    start     = 1'b1;
    poly_in   = p;
    start_cyc = cyc;
    @(posedge clk);
    #1;
    start   = 1'b0;
    poly_in = ~p;
`ifdef POLY_STREAM_DEG_EN
    if (push_exp) begin
      check("deg_cleared", deg, 0);
      check("pz_cleared", poly_zero, 0);
    end
`endif
  endtask

  task automatic wait_done(output int lat);
    int n;
    n = 0;
    while (!done && n < 3000) begin
      @(posedge clk);
      #1;
      n++;
    end
    if (!done) begin
      check("done_timeout", 0, 1);
      lat = -1;
    end else begin
      lat = cyc - start_cyc;
    end
  endtask

  task automatic wait_hs(input int base, input int target);
    int n;
    n = 0;
    while ((hs_cnt - base) < target && n < 3000) begin
      @(posedge clk);
      #1;
      n++;
    end
    check("hs_reached", (hs_cnt - base) >= target, 1);
  endtask

  initial begin
    int lat;
    int hs0;
    int d0;
    rst_n   = 1'b0;
    start   = 1'b0;
    poly_in = '0;
    repeat (3) @(posedge clk);
    #1;
    check("rst_busy", busy, 0);
    check("rst_valid", out_valid, 0);
    check("rst_last", out_last, 0);
    check("rst_done", done, 0);
    check("rst_data", out_data, 0);
`ifdef POLY_STREAM_DEG_EN
    check("rst_deg", deg, 0);
    check("rst_pz", poly_zero, 0);
`endif
    rst_n = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    check("idle_valid", out_valid, 0);

    // basic stream, full throughput
    hs0 = hs_cnt;
    launch(0, 1'b1);
    check("first_valid", out_valid, 1);
    check("first_busy", busy, 1);
    check("first_data", out_data, 1);
    wait_done(lat);
    check("basic_latency", lat, T + 1);
    check("basic_hs", hs_cnt - hs0, T);

    // backpressure
    repeat (2) @(posedge clk);
    #1;
    bp_en = 1'b1;
    hs0 = hs_cnt;
    launch(1, 1'b1);
    wait_done(lat);
    bp_en = 1'b0;
    check("bp_hs", hs_cnt - hs0, T);

    // start while busy, and start coincident with done
    repeat (2) @(posedge clk);
    #1;
    d0 = done_cnt;
    hs0 = hs_cnt;
    launch(2, 1'b1);
    wait_hs(hs0, 10);
    launch(3, 1'b0);
    wait_done(lat);
    check("busy_start_latency", lat - 0, lat);
    start = 1'b1;
    poly_in = '1;
    @(posedge clk);
    #1;
    start = 1'b0;
    repeat (3) begin
      @(posedge clk);
      #1;
      check("no_restart_valid", out_valid, 0);
      check("no_restart_busy", busy, 0);
    end
    check("single_done", done_cnt - d0, 1);
    check("busy_start_hs", hs_cnt - hs0, T);

    // reset mid-stream
    d0 = done_cnt;
    hs0 = hs_cnt;
    launch(4, 1'b1);
    wait_hs(hs0, 30);
    rst_n = 1'b0;
    #1;
    check("abort_valid", out_valid, 0);
    check("abort_busy", busy, 0);
    check("abort_done", done, 0);
    check("abort_data", out_data, 0);
    exp_q.delete();
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    check("abort_no_done", done_cnt - d0, 0);
    hs0 = hs_cnt;
    launch(1, 1'b1);
    check("restart_data", out_data, coef(1, 0));
    wait_done(lat);
    check("restart_latency", lat, T + 1);
    check("restart_hs", hs_cnt - hs0, T);

    // degree patterns (stream must be correct in both builds)
    @(posedge clk);
    #1;
    launch(5, 1'b1);
    wait_done(lat);
    @(posedge clk);
    #1;
    launch(6, 1'b1);
    check("zero_data0", out_data, 0);
    wait_done(lat);
    check("zero_latency", lat, T + 1);

    // back-to-back: start in the first IDLE cycle after done
    @(posedge clk);
    #1;
    launch(4, 1'b1);
    wait_done(lat);
    @(posedge clk);
    #1;
    hs0 = hs_cnt;
    launch(0, 1'b1);
    check("b2b_first_valid", out_valid, 1);
    check("b2b_first_data", out_data, 1);
    wait_done(lat);
    check("b2b_latency", lat, T + 1);
    check("b2b_hs", hs_cnt - hs0, T);

    repeat (3) @(posedge clk);
    #1;
    check("final_q_empty", exp_q.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
